dpram_access_arbiter: RTL and testbench
=======================================

// Module: dpram_access_arbiter
// PURPOSE
//  Shares one synchronous_dualport_ram between two write clients and two read clients.
//  - Round-robin arbitration, run independently on the RAM write port and read port.
//  - Registers the RAM strobes and tags every read so the returned data goes back to its owner.
//  - Sits between the client engines and the RAM instance.
// PARAMETERS
//  ram_width  8   data width of the RAM word
//  ram_depth  16  number of RAM words
//  add_size   4   address width, log2(ram_depth)
// PORTS
//  clk           in   1          single clock, rising edge
//  rst           in   1          asynchronous reset, active-low
//  wr0_req       in   1          write client 0 request; hold until granted
//  wr0_add       in   add_size   write client 0 address
//  wr0_data      in   ram_width  write client 0 data
//  wr0_gnt       out  1          write client 0 granted this cycle
//  wr1_req/wr1_add/wr1_data/wr1_gnt   same as client 0, for write client 1
//  rd0_req       in   1          read client 0 request; hold until granted
//  rd0_add       in   add_size   read client 0 address
//  rd0_gnt       out  1          read client 0 granted this cycle
//  rd1_req/rd1_add/rd1_gnt            same as client 0, for read client 1
//  rd_data       out  ram_width  returned read data, shared by both read clients
//  rd0_valid     out  1          rd_data belongs to read client 0
//  rd1_valid     out  1          rd_data belongs to read client 1
//  ram_data_in   out  ram_width  to RAM data_in
//  ram_write_add out  add_size   to RAM write_add
//  ram_read_add  out  add_size   to RAM read_add
//  ram_write     out  1          to RAM write strobe
//  ram_read      out  1          to RAM read strobe
//  ram_data_out  in   ram_width  from RAM data_out; valid 1 cycle after ram_read
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): every registered output goes to 0, including all ram_*, rd_data and valids.
//    Both round-robin pointers reset so client 0 has priority first.
//  - Grants are combinational from req, pointer and hazard state. At most one wr_gnt and one rd_gnt per cycle.
//  - Round-robin, per port:
//    - only one client requesting -> that client is granted;
//    - both requesting -> the client not granted most recently is granted;
//    - the pointer updates only on a grant.
//  - Address and data are captured on the grant edge. The client drops or changes req on the cycle after gnt.
//  - Write path: gnt in cycle N -> ram_write=1 with add/data in cycle N+1. With no grant, ram_write=0.
//  - Read path:
//    - gnt in cycle N -> ram_read=1 in cycle N+1, with a 1-bit owner tag registered alongside;
//    - cycle N+2 -> rd_data=ram_data_out registered, and rdX_valid=1 for the tag owner.
//    - Read latency is 2 cycles from gnt to valid. Back-to-back grants give one valid per cycle.
//  - Same-address hazard:
//    - if the candidate read address equals the write address granted in the same cycle, the read grant is withheld;
//    - the pointer does not move and the deferred client keeps priority next cycle;
//    - result: a read always observes completed writes.
//  - Reads and writes to different addresses proceed in the same cycle.
//  - No req in a cycle -> no gnt, no strobe; pointer holds.
//  - Reset mid-operation: in-flight reads are discarded and no valid is produced after rst releases.
//    Clients must re-request.
//  - Address wrap: addresses are add_size bits and map directly, with no range check.
// STRUCTURE
//  - Shared package holds the client-id localparams (CLIENT0=1'b0, CLIENT1=1'b1) and the default widths.
//  - One sub-module, rr_arb2: 2-way round-robin arbiter with an enable input for the hazard inhibit.
//    Instantiated twice: write port and read port.
//  - The top level holds the strobe registers, the tag pipeline, the hazard compare and the return mux.
// TESTING
//  1. Reset: hold rst=0 for 2 cycles with all reqs high -> no gnt, all ram_* = 0, no valid.
//  2. Single write: wr0 at 4'h3 with 8'hA5 -> wr0_gnt in cycle N; ram_write=1, add=3, data=A5 in N+1.
//     Then rd1 at 4'h3 -> rd1_valid with rd_data=A5 two cycles after rd1_gnt.
//  3. Fairness: wr0_req and wr1_req held high for 6 cycles -> grants alternate 0,1,0,1,0,1.
//     Same check with both read reqs high -> rd grants alternate.
//  4. Hazard: wr1 at 4'h7 (8'h3C) and rd0 at 4'h7 in the same cycle -> wr1_gnt, rd0 deferred one cycle.
//     rd0_valid then returns 3C, not the old contents.
//  5. Pipelined reads: rd0 at addr 1, rd1 at addr 2, rd0 at addr 3 on consecutive cycles, after preloading 11/22/33
//     -> valids on consecutive cycles with the correct owner and data.
//  6. Reset mid-read: assert rst=0 one cycle after rd0_gnt -> rd0_valid never asserts; pointer back to client 0.

Source files
------------

// File: rtl/dpram_access_arbiter_pkg.sv
// Shared definitions for the dual-port RAM access arbiter: client ids and default geometry.
package dpram_access_arbiter_pkg;

    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

    localparam int DEF_RAM_WIDTH = 8;
    localparam int DEF_RAM_DEPTH = 16;
    localparam int DEF_ADD_SIZE  = 4;

    // One-hot form of a client id, bit 0 for CLIENT0 and bit 1 for CLIENT1.
    function automatic logic [1:0] client_onehot(input logic id);
        return (id == CLIENT1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dpram_access_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with an enable that can veto the grant without moving the pointer.
module rr_arb2
    import dpram_access_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt,
    output logic       o_cand
);

    logic r_prio;
    logic w_fire;

    // o_cand is the client that would win if allowed; the top uses it for the hazard compare.
    always_comb begin
        o_cand = CLIENT0;
        if (i_req == 2'b11) begin
            o_cand = r_prio;
        end else if (i_req[1]) begin
            o_cand = CLIENT1;
        end
    end

    assign w_fire = (|i_req) & i_en & rst;
    assign o_gnt  = w_fire ? client_onehot(o_cand) : 2'b00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prio <= CLIENT0;
        end else if (w_fire) begin
            r_prio <= ~o_cand;
        end
    end

endmodule

// File: rtl/dpram_access_arbiter.sv
// Shares one synchronous dual-port RAM between two write clients and two read clients,
// arbitrating each RAM port round-robin and tagging reads so data returns to its owner.
module dpram_access_arbiter
    import dpram_access_arbiter_pkg::*;
#(
    parameter int ram_width = DEF_RAM_WIDTH,
    parameter int ram_depth = DEF_RAM_DEPTH,
    parameter int add_size  = DEF_ADD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr0_req,
    input  logic [add_size-1:0]  wr0_add,
    input  logic [ram_width-1:0] wr0_data,
    output logic                 wr0_gnt,
    input  logic                 wr1_req,
    input  logic [add_size-1:0]  wr1_add,
    input  logic [ram_width-1:0] wr1_data,
    output logic                 wr1_gnt,
    input  logic                 rd0_req,
    input  logic [add_size-1:0]  rd0_add,
    output logic                 rd0_gnt,
    input  logic                 rd1_req,
    input  logic [add_size-1:0]  rd1_add,
    output logic                 rd1_gnt,
    output logic [ram_width-1:0] rd_data,
    output logic                 rd0_valid,
    output logic                 rd1_valid,
    output logic [ram_width-1:0] ram_data_in,
    output logic [add_size-1:0]  ram_write_add,
    output logic [add_size-1:0]  ram_read_add,
    output logic                 ram_write,
    output logic                 ram_read,
    input  logic [ram_width-1:0] ram_data_out
);

    if (ram_depth != (1 << add_size)) begin : g_depth_mismatch
        $error("dpram_access_arbiter: ram_depth must equal 2**add_size");
    end

    logic [1:0]           w_wr_gnt;
    logic                 w_wr_cand;
    logic [add_size-1:0]  w_wr_add;
    logic [ram_width-1:0] w_wr_data;
    logic [1:0]           w_rd_gnt;
    logic                 w_rd_cand;
    logic [add_size-1:0]  w_rd_cand_add;
    logic                 w_hazard;

    logic                 r_ram_write;
    logic [add_size-1:0]  r_ram_write_add;
    logic [ram_width-1:0] r_ram_data_in;
    logic                 r_ram_read;
    logic [add_size-1:0]  r_ram_read_add;
    logic                 r_tag;
    logic [1:0]           r_valid;

    rr_arb2 u_wr_arb (
        .clk    (clk),
        .rst    (rst),
        .i_en   (1'b1),
        .i_req  ({wr1_req, wr0_req}),
        .o_gnt  (w_wr_gnt),
        .o_cand (w_wr_cand)
    );

    assign w_wr_add  = w_wr_cand ? wr1_add  : wr0_add;
    assign w_wr_data = w_wr_cand ? wr1_data : wr0_data;

    // Holding back a read that collides with this cycle's write makes it land after the write.
    assign w_rd_cand_add = w_rd_cand ? rd1_add : rd0_add;
    assign w_hazard      = (|w_wr_gnt) && (w_rd_cand_add == w_wr_add);

    rr_arb2 u_rd_arb (
        .clk    (clk),
        .rst    (rst),
        .i_en   (~w_hazard),
        .i_req  ({rd1_req, rd0_req}),
        .o_gnt  (w_rd_gnt),
        .o_cand (w_rd_cand)
    );

    assign wr0_gnt = w_wr_gnt[0];
    assign wr1_gnt = w_wr_gnt[1];
    assign rd0_gnt = w_rd_gnt[0];
    assign rd1_gnt = w_rd_gnt[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ram_write     <= 1'b0;
            r_ram_write_add <= '0;
            r_ram_data_in   <= '0;
        end else begin
            r_ram_write <= |w_wr_gnt;
            if (|w_wr_gnt) begin
                r_ram_write_add <= w_wr_add;
                r_ram_data_in   <= w_wr_data;
            end
        end
    end

    // The owner tag travels with the read strobe, then becomes the valid for the returning word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ram_read     <= 1'b0;
            r_ram_read_add <= '0;
            r_tag          <= CLIENT0;
            r_valid        <= 2'b00;
        end else begin
            r_ram_read <= |w_rd_gnt;
            if (|w_rd_gnt) begin
                r_ram_read_add <= w_rd_cand_add;
                r_tag          <= w_rd_cand;
            end
            r_valid <= r_ram_read ? client_onehot(r_tag) : 2'b00;
        end
    end

    assign ram_write     = r_ram_write;
    assign ram_write_add = r_ram_write_add;
    assign ram_data_in   = r_ram_data_in;
    assign ram_read      = r_ram_read;
    assign ram_read_add  = r_ram_read_add;
    assign rd0_valid     = r_valid[0];
    assign rd1_valid     = r_valid[1];

    // The RAM's own output register is the data stage; the mux only forwards it with its valid.
    assign rd_data = (|r_valid) ? ram_data_out : '0;

endmodule

// File: tb/tb_dpram_access_arbiter.sv
// Directed bench for dpram_access_arbiter with a behavioural synchronous dual-port RAM attached.
module tb_dpram_access_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr0_req, wr1_req, rd0_req, rd1_req;
    logic [3:0] wr0_add, wr1_add, rd0_add, rd1_add;
    logic [7:0] wr0_data, wr1_data;
    logic       wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt;
    logic [7:0] rd_data;
    logic       rd0_valid, rd1_valid;
    logic [7:0] ram_data_in;
    logic [3:0] ram_write_add, ram_read_add;
    logic       ram_write, ram_read;
    logic [7:0] ram_data_out = 8'h00;
    logic [7:0] mem [16];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dpram_access_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .wr0_req       (wr0_req),
        .wr0_add       (wr0_add),
        .wr0_data      (wr0_data),
        .wr0_gnt       (wr0_gnt),
        .wr1_req       (wr1_req),
        .wr1_add       (wr1_add),
        .wr1_data      (wr1_data),
        .wr1_gnt       (wr1_gnt),
        .rd0_req       (rd0_req),
        .rd0_add       (rd0_add),
        .rd0_gnt       (rd0_gnt),
        .rd1_req       (rd1_req),
        .rd1_add       (rd1_add),
        .rd1_gnt       (rd1_gnt),
        .rd_data       (rd_data),
        .rd0_valid     (rd0_valid),
        .rd1_valid     (rd1_valid),
        .ram_data_in   (ram_data_in),
        .ram_write_add (ram_write_add),
        .ram_read_add  (ram_read_add),
        .ram_write     (ram_write),
        .ram_read      (ram_read),
        .ram_data_out  (ram_data_out)
    );

    // Address 7 starts non-zero so a read racing the write to it would show stale data.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] <= (i == 7) ? 8'hFF : 8'h00;
    end

    always @(posedge clk) begin
        if (ram_write) mem[ram_write_add] <= ram_data_in;
        if (ram_read)  ram_data_out <= mem[ram_read_add];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic w0r, input logic [3:0] w0a, input logic [7:0] w0d,
                                 input logic w1r, input logic [3:0] w1a, input logic [7:0] w1d,
                                 input logic r0r, input logic [3:0] r0a,
                                 input logic r1r, input logic [3:0] r1a);
        wr0_req = w0r; wr0_add = w0a; wr0_data = w0d;
        wr1_req = w1r; wr1_add = w1a; wr1_data = w1d;
        rd0_req = r0r; rd0_add = r0a;
        rd1_req = r1r; rd1_add = r1a;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0, 4'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        // Reset held with every request high.
        applyStimulus(1'b1, 4'h0, 8'h00, 1'b1, 4'h0, 8'h00, 1'b1, 4'h0, 1'b1, 4'h0);
        sample();
        sample();
        checkOutput("rst_wr_gnt", 32'({wr1_gnt, wr0_gnt}), 32'h0);
        checkOutput("rst_rd_gnt", 32'({rd1_gnt, rd0_gnt}), 32'h0);
        checkOutput("rst_strobes", 32'({ram_write, ram_read}), 32'h0);
        checkOutput("rst_ram_bus", 32'({ram_write_add, ram_read_add, ram_data_in}), 32'h0);
        checkOutput("rst_valid", 32'({rd1_valid, rd0_valid}), 32'h0);
        checkOutput("rst_rd_data", 32'(rd_data), 32'h0);
        rst = 1'b1;
        idle();
        tick();

        // Single write then read-back by rd1.
        applyStimulus(1'b1, 4'h3, 8'hA5, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0, 4'h0);
        sample();
        checkOutput("wr_single_gnt", 32'({wr1_gnt, wr0_gnt}), 32'h1);
        tick();
        idle();
        sample();
        checkOutput("wr_single_strobe", 32'({ram_write, ram_write_add, ram_data_in}), 32'h13A5);
        tick();
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b1, 4'h3);
        sample();
        checkOutput("rd_single_gnt", 32'({rd1_gnt, rd0_gnt}), 32'h2);
        tick();
        idle();
        sample();
        checkOutput("rd_single_strobe", 32'({ram_read, ram_read_add}), 32'h13);
        checkOutput("rd_single_early", 32'({rd1_valid, rd0_valid}), 32'h0);
        tick();
        sample();
        checkOutput("rd_single_valid", 32'({rd1_valid, rd0_valid}), 32'h2);
        checkOutput("rd_single_data", 32'(rd_data), 32'hA5);
        tick();

        // Fresh reset so both pointers start at client 0, then both pairs contend for 6 cycles.
        rst = 1'b0;
        sample();
        rst = 1'b1;
        tick();
        applyStimulus(1'b1, 4'h4, 8'h44, 1'b1, 4'h5, 8'h55, 1'b1, 4'h8, 1'b1, 4'h9);
        for (int i = 0; i < 6; i++) begin
            sample();
            checkOutput($sformatf("fair_wr_%0d", i), 32'({wr1_gnt, wr0_gnt}), (i % 2 == 1) ? 32'h2 : 32'h1);
            checkOutput($sformatf("fair_rd_%0d", i), 32'({rd1_gnt, rd0_gnt}), (i % 2 == 1) ? 32'h2 : 32'h1);
            tick();
        end
        idle();
        repeat (3) tick();

        // Read of the address being written this cycle is deferred by one cycle.
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b1, 4'h7, 8'h3C, 1'b1, 4'h7, 1'b0, 4'h0);
        sample();
        checkOutput("haz_wr_gnt", 32'({wr1_gnt, wr0_gnt}), 32'h2);
        checkOutput("haz_rd_held", 32'({rd1_gnt, rd0_gnt}), 32'h0);
        tick();
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 4'h7, 1'b0, 4'h0);
        sample();
        checkOutput("haz_rd_gnt", 32'({rd1_gnt, rd0_gnt}), 32'h1);
        checkOutput("haz_wr_strobe", 32'({ram_write, ram_write_add, ram_data_in}), 32'h173C);
        tick();
        idle();
        sample();
        checkOutput("haz_rd_strobe", 32'({ram_read, ram_read_add}), 32'h17);
        tick();
        sample();
        checkOutput("haz_valid", 32'({rd1_valid, rd0_valid}), 32'h1);
        checkOutput("haz_data", 32'(rd_data), 32'h3C);
        tick();

        // Preload 11/22/33 then pipelined reads rd0@1, rd1@2, rd0@3.
        applyStimulus(1'b1, 4'h1, 8'h11, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0, 4'h0);
        sample();
        checkOutput("pre_gnt_1", 32'({wr1_gnt, wr0_gnt}), 32'h1);
        tick();
        applyStimulus(1'b1, 4'h2, 8'h22, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0, 4'h0);
        sample();
        checkOutput("pre_gnt_2", 32'({wr1_gnt, wr0_gnt}), 32'h1);
        tick();
        applyStimulus(1'b1, 4'h3, 8'h33, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0, 4'h0);
        sample();
        tick();
        idle();
        tick();
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 4'h1, 1'b0, 4'h0);
        sample();
        checkOutput("pipe_gnt_a", 32'({rd1_gnt, rd0_gnt}), 32'h1);
        tick();
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b1, 4'h2);
        sample();
        checkOutput("pipe_gnt_b", 32'({rd1_gnt, rd0_gnt}), 32'h2);
        tick();
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 4'h3, 1'b0, 4'h0);
        sample();
        checkOutput("pipe_gnt_c", 32'({rd1_gnt, rd0_gnt}), 32'h1);
        checkOutput("pipe_valid_a", 32'({rd1_valid, rd0_valid, rd_data}), 32'h111);
        tick();
        idle();
        sample();
        checkOutput("pipe_valid_b", 32'({rd1_valid, rd0_valid, rd_data}), 32'h222);
        tick();
        sample();
        checkOutput("pipe_valid_c", 32'({rd1_valid, rd0_valid, rd_data}), 32'h133);
        tick();
        sample();
        checkOutput("pipe_drain", 32'({rd1_valid, rd0_valid}), 32'h0);
        tick();

        // Reset one cycle after a read grant discards the in-flight read.
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 4'h1, 1'b0, 4'h0);
        sample();
        checkOutput("mid_rd_gnt", 32'({rd1_gnt, rd0_gnt}), 32'h1);
        tick();
        idle();
        rst = 1'b0;
        sample();
        checkOutput("mid_rst_read", 32'(ram_read), 32'h0);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            sample();
            checkOutput($sformatf("mid_no_valid_%0d", i), 32'({rd1_valid, rd0_valid}), 32'h0);
            tick();
        end
        applyStimulus(1'b1, 4'h4, 8'h44, 1'b1, 4'h5, 8'h55, 1'b1, 4'h8, 1'b1, 4'h9);
        sample();
        checkOutput("mid_ptr_wr", 32'({wr1_gnt, wr0_gnt}), 32'h1);
        checkOutput("mid_ptr_rd", 32'({rd1_gnt, rd0_gnt}), 32'h1);
        tick();
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
